fft4_stream: RTL and testbench
==============================

FFT4_STREAM -- requirements
Module: fft4_stream

Interface
REQ-001 Parameter DATA_W, default 8, sample component width (signed two's complement, ≥4).
REQ-002 Parameter OUT_W, derived, not overridable: DATA_W with FFT_BLOCK_SCALE_EN defined, DATA_W+2 without.
REQ-003 Port clk  in  1  single clock, rising edge.
REQ-004 Port rst_n  in  1  asynchronous active-low reset.
REQ-005 Port ena  in  1  global enable; low freezes all state.
REQ-006 Port inverse  in  1  transform mode (0 forward, 1 inverse); sampled with the first sample of a frame.
REQ-007 Port in_valid  in  1  input sample valid.
REQ-008 Port in_ready  out  1  block can accept a sample.
REQ-009 Ports in_re, in_im  in  DATA_W each  input sample real and imaginary parts.
REQ-010 Port out_valid  out  1  output bin valid.
REQ-011 Port out_ready  in  1  downstream accepts bin.
REQ-012 Ports out_re, out_im  out  OUT_W each  output bin real and imaginary parts.
REQ-013 Port out_idx  out  2  bin index k of the current output.
REQ-014 Port busy  out  1  high in any state other than LOAD.

Function
REQ-015 FSM states LOAD, STAGE1, STAGE2, UNLOAD; reset state LOAD.
REQ-016 A transfer occurs on a rising clk edge with ena=1 and valid=1 and ready=1.
REQ-017 LOAD: in_ready=1; accepted samples fill x0..x3 in order, 2-bit counter wraps 3→0, fourth accepted sample moves the FSM to STAGE1.
REQ-018 STAGE1 (one cycle): a=x0+x2, b=x0−x2, c=x1+x3, d=x1−x3, width DATA_W+1.
REQ-019 STAGE2 (one cycle): X0=a+c, X2=a−c, X1=b+t, X3=b−t, width DATA_W+2; t=−j·d forward (re=d.im, im=−d.re), t=+j·d inverse (re=−d.im, im=d.re); no multiplier.
REQ-020 Latency: out_valid rises on the 2nd cycle after the fourth input transfer; in_ready=0 from STAGE1 until UNLOAD completes.
REQ-021 UNLOAD: bins presented in natural order k=0,1,2,3 on out_idx; out_re/out_im/out_idx held stable while out_valid=1 and out_ready=0; after the k=3 transfer the FSM returns to LOAD with in_ready=1 next cycle.
REQ-022 out_valid=0 and out_re/out_im/out_idx=0 in every state except UNLOAD.
REQ-023 ena=0: no state, counter or register changes; in_ready and out_valid forced 0; out_re/out_im/out_idx keep their values.
REQ-024 The inverse transform applies no 1/N normalisation beyond REQ-027.
REQ-025 inverse changes mid-frame do not affect the frame in progress.

Reset
REQ-026 rst_n low, at any time including mid-frame: FSM→LOAD, counters 0, sample and result registers 0, latched mode 0; outputs in_ready=1 (once rst_n high), out_valid=0, busy=0, out_re/out_im/out_idx=0; partial frames are discarded.

Configuration
REQ-027 FFT_BLOCK_SCALE_EN defined: each stage result is arithmetic-shifted right by 1 (floor) and truncated to DATA_W; OUT_W=DATA_W; no overflow possible.
REQ-028 FFT_BLOCK_SCALE_EN undefined: full precision, no shift; OUT_W=DATA_W+2; no overflow possible.

Structure
REQ-029 Package fft_pkg holds the FSM state enum, the frame length constant N=4 and the twiddle-mode enum.
REQ-030 Sub-module fft_bfly: combinational radix-2 butterfly (sum/difference, parametrised width, optional >>>1 per REQ-027); instantiated for both stages.

Verification (DATA_W=8)
REQ-031 Unscaled, impulse x=[1,0,0,0] forward -> X0..X3 all = 1+0j; out_valid 2 cycles after 4th transfer.
REQ-032 Unscaled, x=[0,1,0,0]: forward -> [1, −j, −1, +j]; inverse -> [1, +j, −1, −j].
REQ-033 Unscaled, all x=−128+0j -> X0=−512, X1=X2=X3=0 (full-range corner, no wrap).
REQ-034 Scaled, DC all x=10 -> X0=10, others 0; scaled x=[−1,0,0,0] -> all X re=−1 (floor rounding).
REQ-035 out_ready held low 5 cycles during k=1 -> out_idx=1 and values stable, no bin lost or repeated; in_valid asserted throughout UNLOAD is not accepted.
REQ-036 rst_n pulsed after 2 accepted samples, then a full frame -> result depends only on the post-reset frame; ena=0 for 3 cycles mid-STAGE1 -> latency extended by exactly 3 cycles, results unchanged.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared types and constants for the 4-point streaming FFT: FSM states,
// frame length and twiddle mode.
package fft_pkg;

  localparam int N = 4;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    STAGE1 = 2'd1,
    STAGE2 = 2'd2,
    UNLOAD = 2'd3
  } fft_state_e;

  typedef enum logic {
    TW_FWD = 1'b0,
    TW_INV = 1'b1
  } tw_mode_e;

endpackage

// File: rtl/fft_bfly.sv
// Combinational complex radix-2 butterfly: s = a + b, d = a - b.
// With FFT_BLOCK_SCALE_EN defined each result is floor-shifted right by one.
module fft_bfly #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 9
) (
  input  logic signed [IN_W-1:0]  i_a_re,
  input  logic signed [IN_W-1:0]  i_a_im,
  input  logic signed [IN_W-1:0]  i_b_re,
  input  logic signed [IN_W-1:0]  i_b_im,
  output logic signed [OUT_W-1:0] o_s_re,
  output logic signed [OUT_W-1:0] o_s_im,
  output logic signed [OUT_W-1:0] o_d_re,
  output logic signed [OUT_W-1:0] o_d_im
);

  // Callers size OUT_W so the kept bits always hold the true result.
  function automatic logic signed [OUT_W-1:0] scale_fn(input logic signed [IN_W:0] v);
`ifdef FFT_BLOCK_SCALE_EN
    return OUT_W'(v >>> 1);
`else
    return OUT_W'(v);
`endif
  endfunction

  logic signed [IN_W:0] w_s_re, w_s_im, w_d_re, w_d_im;

  assign w_s_re = (IN_W+1)'(i_a_re) + (IN_W+1)'(i_b_re);
  assign w_s_im = (IN_W+1)'(i_a_im) + (IN_W+1)'(i_b_im);
  assign w_d_re = (IN_W+1)'(i_a_re) - (IN_W+1)'(i_b_re);
  assign w_d_im = (IN_W+1)'(i_a_im) - (IN_W+1)'(i_b_im);

  assign o_s_re = scale_fn(w_s_re);
  assign o_s_im = scale_fn(w_s_im);
  assign o_d_re = scale_fn(w_d_re);
  assign o_d_im = scale_fn(w_d_im);

endmodule

// File: rtl/fft4_stream.sv
// Streaming 4-point radix-2 FFT/IFFT: load 4 samples, two butterfly stages,
// unload 4 bins in natural order. FFT_BLOCK_SCALE_EN enables per-stage >>>1.
module fft4_stream
  import fft_pkg::*;
#(
  parameter int DATA_W = 8,
`ifdef FFT_BLOCK_SCALE_EN
  localparam int OUT_W = DATA_W
`else
  localparam int OUT_W = DATA_W + 2
`endif
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ena,
  input  logic                     inverse,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_re,
  input  logic signed [DATA_W-1:0] in_im,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OUT_W-1:0]  out_re,
  output logic signed [OUT_W-1:0]  out_im,
  output logic [1:0]               out_idx,
  output logic                     busy
);

`ifdef FFT_BLOCK_SCALE_EN
  localparam int S1_W = DATA_W;
`else
  localparam int S1_W = DATA_W + 1;
`endif
  // One extra bit so that negating d for the twiddle can never wrap.
  localparam int T_W = S1_W + 1;

  fft_state_e r_state, w_state_nxt;
  logic [1:0] r_cnt;
  tw_mode_e   r_mode;
  logic       w_in_fire, w_out_fire;

  logic signed [DATA_W-1:0] r_x_re_p0 [N];
  logic signed [DATA_W-1:0] r_x_im_p0 [N];
  logic signed [S1_W-1:0]   r_a_re_p1, r_a_im_p1, r_b_re_p1, r_b_im_p1;
  logic signed [S1_W-1:0]   r_c_re_p1, r_c_im_p1, r_d_re_p1, r_d_im_p1;
  logic signed [OUT_W-1:0]  r_y_re_p2 [N];
  logic signed [OUT_W-1:0]  r_y_im_p2 [N];

  logic signed [S1_W-1:0]   w_a_re, w_a_im, w_b_re, w_b_im;
  logic signed [S1_W-1:0]   w_c_re, w_c_im, w_d_re, w_d_im;
  logic signed [T_W-1:0]    w_a_re_x, w_a_im_x, w_b_re_x, w_b_im_x;
  logic signed [T_W-1:0]    w_c_re_x, w_c_im_x, w_d_re_x, w_d_im_x;
  logic signed [T_W-1:0]    w_t_re, w_t_im;
  logic signed [OUT_W-1:0]  w_y0_re, w_y0_im, w_y1_re, w_y1_im;
  logic signed [OUT_W-1:0]  w_y2_re, w_y2_im, w_y3_re, w_y3_im;

  assign in_ready   = ena && (r_state == LOAD);
  assign out_valid  = ena && (r_state == UNLOAD);
  assign busy       = (r_state != LOAD);
  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = out_ready && out_valid;

  assign out_re  = (r_state == UNLOAD) ? r_y_re_p2[r_cnt] : '0;
  assign out_im  = (r_state == UNLOAD) ? r_y_im_p2[r_cnt] : '0;
  assign out_idx = (r_state == UNLOAD) ? r_cnt : 2'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= LOAD;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (ena) begin
      case (r_state)
        LOAD:    if (w_in_fire && r_cnt == 2'd3) w_state_nxt = STAGE1;
        STAGE1:  w_state_nxt = STAGE2;
        STAGE2:  w_state_nxt = UNLOAD;
        UNLOAD:  if (w_out_fire && r_cnt == 2'd3) w_state_nxt = LOAD;
        default: w_state_nxt = LOAD;
      endcase
    end
  end

  // Stage 1: even/odd pair butterflies on the loaded samples
  fft_bfly #(.IN_W(DATA_W), .OUT_W(S1_W)) u_bfly_s1_ev (
    .i_a_re(r_x_re_p0[0]), .i_a_im(r_x_im_p0[0]),
    .i_b_re(r_x_re_p0[2]), .i_b_im(r_x_im_p0[2]),
    .o_s_re(w_a_re), .o_s_im(w_a_im), .o_d_re(w_b_re), .o_d_im(w_b_im)
  );

  fft_bfly #(.IN_W(DATA_W), .OUT_W(S1_W)) u_bfly_s1_od (
    .i_a_re(r_x_re_p0[1]), .i_a_im(r_x_im_p0[1]),
    .i_b_re(r_x_re_p0[3]), .i_b_im(r_x_im_p0[3]),
    .o_s_re(w_c_re), .o_s_im(w_c_im), .o_d_re(w_d_re), .o_d_im(w_d_im)
  );

  // Stage 2: twiddle by -j (forward) or +j (inverse) is a swap and a negate
  assign w_a_re_x = T_W'(r_a_re_p1);
  assign w_a_im_x = T_W'(r_a_im_p1);
  assign w_b_re_x = T_W'(r_b_re_p1);
  assign w_b_im_x = T_W'(r_b_im_p1);
  assign w_c_re_x = T_W'(r_c_re_p1);
  assign w_c_im_x = T_W'(r_c_im_p1);
  assign w_d_re_x = T_W'(r_d_re_p1);
  assign w_d_im_x = T_W'(r_d_im_p1);
  assign w_t_re   = (r_mode == TW_FWD) ? w_d_im_x : -w_d_im_x;
  assign w_t_im   = (r_mode == TW_FWD) ? -w_d_re_x : w_d_re_x;

  fft_bfly #(.IN_W(T_W), .OUT_W(OUT_W)) u_bfly_s2_ac (
    .i_a_re(w_a_re_x), .i_a_im(w_a_im_x),
    .i_b_re(w_c_re_x), .i_b_im(w_c_im_x),
    .o_s_re(w_y0_re), .o_s_im(w_y0_im), .o_d_re(w_y2_re), .o_d_im(w_y2_im)
  );

  fft_bfly #(.IN_W(T_W), .OUT_W(OUT_W)) u_bfly_s2_bt (
    .i_a_re(w_b_re_x), .i_a_im(w_b_im_x),
    .i_b_re(w_t_re), .i_b_im(w_t_im),
    .o_s_re(w_y1_re), .o_s_im(w_y1_im), .o_d_re(w_y3_re), .o_d_im(w_y3_im)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= 2'd0;
      r_mode <= TW_FWD;
      for (int i = 0; i < N; i++) begin
        r_x_re_p0[i] <= '0;
        r_x_im_p0[i] <= '0;
        r_y_re_p2[i] <= '0;
        r_y_im_p2[i] <= '0;
      end
      r_a_re_p1 <= '0; r_a_im_p1 <= '0; r_b_re_p1 <= '0; r_b_im_p1 <= '0;
      r_c_re_p1 <= '0; r_c_im_p1 <= '0; r_d_re_p1 <= '0; r_d_im_p1 <= '0;
    end else if (ena) begin
      if (w_in_fire) begin
        r_x_re_p0[r_cnt] <= in_re;
        r_x_im_p0[r_cnt] <= in_im;
        if (r_cnt == 2'd0) r_mode <= tw_mode_e'(inverse);
      end
      if (w_in_fire || w_out_fire) r_cnt <= r_cnt + 2'd1;
      if (r_state == STAGE1) begin
        r_a_re_p1 <= w_a_re; r_a_im_p1 <= w_a_im; r_b_re_p1 <= w_b_re; r_b_im_p1 <= w_b_im;
        r_c_re_p1 <= w_c_re; r_c_im_p1 <= w_c_im; r_d_re_p1 <= w_d_re; r_d_im_p1 <= w_d_im;
      end
      if (r_state == STAGE2) begin
        r_y_re_p2[0] <= w_y0_re; r_y_im_p2[0] <= w_y0_im;
        r_y_re_p2[1] <= w_y1_re; r_y_im_p2[1] <= w_y1_im;
        r_y_re_p2[2] <= w_y2_re; r_y_im_p2[2] <= w_y2_im;
        r_y_re_p2[3] <= w_y3_re; r_y_im_p2[3] <= w_y3_im;
      end
    end
  end

endmodule

// File: tb/tb_fft4_stream.sv
// Directed bench for fft4_stream (DATA_W=8) with hand-computed bins; the
// FFT_BLOCK_SCALE_EN build selects the scaled vector set.
module tb_fft4_stream;

  localparam int DATA_W = 8;
`ifdef FFT_BLOCK_SCALE_EN
  localparam int OUT_W = DATA_W;
`else
  localparam int OUT_W = DATA_W + 2;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     rst_n, ena, inverse, in_valid, in_ready;
  logic signed [DATA_W-1:0] in_re, in_im;
  logic                     out_valid, out_ready, busy;
  logic signed [OUT_W-1:0]  out_re, out_im;
  logic [1:0]               out_idx;

  fft4_stream #(.DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .inverse(inverse),
    .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_im(in_im),
    .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
    .out_idx(out_idx), .busy(busy)
  );

  int n_chk = 0;
  int n_pass = 0;
  int xr[4], xi[4], er[4], ei[4];

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Mode toggles after the first sample; only the first one may count.
  task automatic send_samples(input int cnt, input logic inv);
    int w;
    for (int i = 0; i < cnt; i++) begin
      in_valid = 1'b1;
      in_re    = DATA_W'(xr[i]);
      in_im    = DATA_W'(xi[i]);
      inverse  = (i == 0) ? inv : ~inv;
      w = 0;
      while (!in_ready && w < 20) begin tick(); w++; end
      if (!in_ready) chk("in_ready_timeout", 0, 1);
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag, input int gap, input int exp_lat);
    int lat = 0;
    chk({tag, "_busy"}, busy, 1);
    if (gap > 0) begin
      ena = 1'b0;
      repeat (gap) begin
        tick(); lat++;
        chk({tag, "_gap_vld"}, out_valid, 0);
      end
      ena = 1'b1;
    end
    while (!out_valid && lat < 20) begin tick(); lat++; end
    chk({tag, "_lat"}, lat, exp_lat);
  endtask

  task automatic unload(input string tag, input int stall_k, input logic hold_in);
    int w;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_valid = hold_in;
      in_re    = 8'sd55;
      in_im    = -8'sd33;
      w = 0;
      while (!out_valid && w < 20) begin tick(); w++; end
      if (!out_valid) chk({tag, "_vld_timeout"}, 0, 1);
      chk({tag, "_idx"}, out_idx, k);
      chk({tag, "_re"}, out_re, er[k]);
      chk({tag, "_im"}, out_im, ei[k]);
      if (hold_in) chk({tag, "_in_rdy"}, in_ready, 0);
      if (k == stall_k) begin
        out_ready = 1'b0;
        repeat (5) begin
          tick();
          chk({tag, "_stall_vld"}, out_valid, 1);
          chk({tag, "_stall_idx"}, out_idx, k);
          chk({tag, "_stall_re"}, out_re, er[k]);
          chk({tag, "_stall_im"}, out_im, ei[k]);
        end
        out_ready = 1'b1;
      end
      tick();
    end
    in_valid = 1'b0;
    chk({tag, "_back_rdy"}, in_ready, 1);
    chk({tag, "_back_busy"}, busy, 0);
    chk({tag, "_idle_re"}, out_re, 0);
  endtask

  task automatic frame(input string tag, input logic inv, input int gap, input int lat);
    send_samples(4, inv);
    wait_out(tag, gap, lat);
    unload(tag, -1, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; ena = 1'b1; inverse = 1'b0; in_valid = 1'b0;
    in_re = '0; in_im = '0; out_ready = 1'b0;
    repeat (2) tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_out_re", out_re, 0);
    chk("rst_out_im", out_im, 0);
    rst_n = 1'b1;
    tick();
    chk("rst_in_ready", in_ready, 1);

`ifdef FFT_BLOCK_SCALE_EN
    xr = '{10, 10, 10, 10}; xi = '{0, 0, 0, 0};
    er = '{10, 0, 0, 0};    ei = '{0, 0, 0, 0};
    frame("sc_dc", 1'b0, 0, 2);

    xr = '{-1, 0, 0, 0};    xi = '{0, 0, 0, 0};
    er = '{-1, -1, -1, -1}; ei = '{0, 0, 0, 0};
    frame("sc_floor", 1'b0, 0, 2);
`else
    xr = '{1, 0, 0, 0};  xi = '{0, 0, 0, 0};
    er = '{1, 1, 1, 1};  ei = '{0, 0, 0, 0};
    frame("imp", 1'b0, 0, 2);

    xr = '{0, 1, 0, 0};  xi = '{0, 0, 0, 0};
    er = '{1, 0, -1, 0}; ei = '{0, -1, 0, 1};
    frame("shift_fwd", 1'b0, 0, 2);

    er = '{1, 0, -1, 0}; ei = '{0, 1, 0, -1};
    frame("shift_inv", 1'b1, 0, 2);

    xr = '{-128, -128, -128, -128}; xi = '{0, 0, 0, 0};
    er = '{-512, 0, 0, 0};          ei = '{0, 0, 0, 0};
    frame("minval", 1'b0, 0, 2);

    // x = [1+2j, 3-j, -2, 4j]
    xr = '{1, 3, -2, 0}; xi = '{2, -1, 0, 4};
    er = '{2, -2, -4, 8}; ei = '{5, -1, -1, 5};
    send_samples(4, 1'b0);
    wait_out("stall", 0, 2);
    unload("stall", 1, 1'b1);

    xr = '{50, 50, 0, 0}; xi = '{7, 7, 0, 0};
    send_samples(2, 1'b1);
    rst_n = 1'b0;
    tick();
    chk("midrst_busy", busy, 0);
    chk("midrst_out_valid", out_valid, 0);
    rst_n = 1'b1;
    tick();
    chk("midrst_in_ready", in_ready, 1);
    xr = '{1, 0, 0, 0}; xi = '{0, 0, 0, 0};
    er = '{1, 1, 1, 1}; ei = '{0, 0, 0, 0};
    frame("post_rst", 1'b0, 0, 2);

    xr = '{0, 1, 0, 0};  xi = '{0, 0, 0, 0};
    er = '{1, 0, -1, 0}; ei = '{0, -1, 0, 1};
    frame("ena_gap", 1'b0, 3, 5);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
